// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: word width,
// FSM encoding and the PC incrementer.
package fetch_seq_pkg;

  localparam int WORD = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // 16-bit incrementer; wraps FFFF -> 0000 with no carry out
  function automatic logic [WORD-1:0] inc16(input logic [WORD-1:0] a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready output register. Flush wins over load so a
// redirect never lets a stale instruction through to decode.
module fetch_buf
  import fetch_seq_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [WORD-1:0] load_data,
  input  logic [WORD-1:0] load_pc,
  input  logic            ready,
  output logic [WORD-1:0] data,
  output logic [WORD-1:0] pc,
  output logic            valid
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      data  <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      pc    <= load_pc;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: owns the PC, reads ROM over req/ack and
// hands instructions to decode through fetch_buf.
//
//   state | meaning
//   IDLE  | PC just loaded (reset or jump); request goes out next cycle
//   REQ   | rom_req high for rom_addr=pc, waiting for rom_ack
//   WAIT  | word held locally, output buffer full; rom_req low
module fetch_seq
  import fetch_seq_pkg::*;
#(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter int          WIDTH      = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] rom_addr,
  output logic             rom_req,
  input  logic             rom_ack,
  input  logic [WIDTH-1:0] rom_data,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_addr,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready
);

  state_t           state, state_n;
  logic [WIDTH-1:0] pc, pc_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             free;

  assign free = !instr_valid || instr_ready;

  // rom_req is registered as (state == REQ), so gating on state also
  // ignores any ack that arrives while no request is out.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    hold_n    = hold;
    load      = 1'b0;
    load_data = rom_data;
    if (jmp) begin
      state_n = IDLE;
      pc_n    = jmp_addr;
      hold_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (rom_ack) begin
            if (free) begin
              load = 1'b1;
              pc_n = inc16(pc);
            end else begin
              hold_n  = rom_data;
              state_n = WAIT;
            end
          end
        end
        WAIT: begin
          if (free) begin
            load      = 1'b1;
            load_data = hold;
            pc_n      = inc16(pc);
            state_n   = REQ;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      hold     <= '0;
      rom_req  <= 1'b0;
      rom_addr <= RESET_ADDR;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      hold     <= hold_n;
      rom_req  <= (state_n == REQ);
      rom_addr <= pc_n;
    end
  end

  fetch_buf u_buf (
    .clock     (clock),
    .reset     (reset),
    .flush     (jmp),
    .load      (load),
    .load_data (load_data),
    .load_pc   (pc),
    .ready     (instr_ready),
    .data      (instr),
    .pc        (instr_pc),
    .valid     (instr_valid)
  );

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: a ROM responder issues acks and queues the expected
// deliveries; a monitor pops and compares whenever decode takes one.
module tb_fetch_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] rom_addr;
  logic        rom_req;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_data = 16'h0;
  logic        jmp = 1'b0;
  logic [15:0] jmp_addr = 16'h0;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;

  always #5 clock = ~clock;

  fetch_seq #(.RESET_ADDR(16'h0000), .WIDTH(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_ack     (rom_ack),
    .rom_data    (rom_data),
    .jmp         (jmp),
    .jmp_addr    (jmp_addr),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  int          n_checks = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_addr = 16'h0;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] key = 16'h0;
  logic [15:0] mon_e;
  int          age = 0;
  int          cur_lat = 0;
  int          lat_cfg = 0;
  bit          rnd_lat = 1'b0;
  bit          acks_on = 1'b1;
  bit          got;

  function automatic logic [15:0] romf(input logic [15:0] a);
    return {a[6:0], a[15:7]} ^ key;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock cycle: drive inputs just after the edge and play the ROM.
  task automatic cyc(input logic rst_v, input logic rdy, input logic j, input logic [15:0] ja);
    @(posedge clock);
    #1;
    reset       = rst_v;
    instr_ready = rdy;
    jmp         = j;
    jmp_addr    = ja;
    rom_ack     = 1'b0;
    rom_data    = 16'($urandom);
    if (rom_req) begin
      if (age == 0) begin
        req_addr = rom_addr;
        cur_lat  = rnd_lat ? int'($urandom_range(0, 3)) : lat_cfg;
      end else begin
        check("rom_addr_stable", rom_addr, req_addr);
      end
      if (acks_on && age >= cur_lat) begin
        rom_ack  = 1'b1;
        rom_data = romf(rom_addr);
        age      = 0;
        if (rst_v && !j) begin
          check("rom_addr_seq", rom_addr, exp_addr);
          exp_q.push_back(rom_addr);
          exp_addr = exp_addr + 16'd1;
        end
      end else begin
        age++;
      end
    end else begin
      age = 0;
      if (acks_on && $urandom_range(0, 4) == 0) begin
        rom_ack  = 1'b1;
        rom_data = 16'hDEAD;
      end
    end
    if (!rst_v) exp_addr = 16'h0000;
    else if (j) exp_addr = ja;
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL deliver_extra: got pc %0h expected no delivery", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check("instr_pc", instr_pc, mon_e);
          check("instr", instr, romf(mon_e));
        end
      end
      if (jmp) exp_q.delete();
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    key = 16'($urandom);

    cyc(0, 1, 0, 16'h0);
    cyc(0, 1, 0, 16'h0);
    check("reset_rom_req", rom_req, 0);
    check("reset_rom_addr", rom_addr, 16'h0000);
    check("reset_instr_valid", instr_valid, 0);
    check("reset_instr", instr, 16'h0);
    check("reset_instr_pc", instr_pc, 16'h0);

    cyc(1, 1, 0, 16'h0);
    check("latency_idle_req", rom_req, 0);
    cyc(1, 1, 0, 16'h0);
    check("latency_req", rom_req, 1);
    check("first_addr", rom_addr, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 16'h0);
      check("seq_valid", instr_valid, 1);
      check("seq_pc", instr_pc, 32'(i));
    end

    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 16'h0);
    check("bp_req_low", rom_req, 0);
    check("bp_valid", instr_valid, 1);
    check("bp_pc", instr_pc, 16'h0003);
    check("bp_instr", instr, romf(16'h0003));
    for (int i = 0; i < 6; i++) cyc(1, 1, 0, 16'h0);

    lat_cfg = 3;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc(1, 1, 0, 16'h0);
      if (rom_req && age == 3) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL jmp_setup: got timeout expected outstanding request");
    end
    cyc(1, 1, 1, 16'h0040);
    lat_cfg = 0;
    cyc(1, 1, 0, 16'h0);
    check("jmp_req_low", rom_req, 0);
    check("jmp_flush", instr_valid, 0);
    cyc(1, 1, 0, 16'h0);
    check("jmp_req", rom_req, 1);
    check("jmp_addr", rom_addr, 16'h0040);
    cyc(1, 1, 0, 16'h0);
    check("jmp_first_pc", instr_pc, 16'h0040);
    check("jmp_first_valid", instr_valid, 1);

    cyc(1, 1, 1, 16'hFFFE);
    cyc(1, 1, 0, 16'h0);
    cyc(1, 1, 0, 16'h0);
    check("wrap_addr0", rom_addr, 16'hFFFE);
    cyc(1, 1, 0, 16'h0);
    check("wrap_addr1", rom_addr, 16'hFFFF);
    cyc(1, 1, 0, 16'h0);
    check("wrap_addr2", rom_addr, 16'h0000);
    cyc(1, 1, 0, 16'h0);
    check("wrap_addr3", rom_addr, 16'h0001);

    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0);
    check("wait_req_low", rom_req, 0);
    check("wait_full", instr_valid, 1);
    cyc(0, 0, 0, 16'h0);
    cyc(1, 1, 0, 16'h0);
    check("mid_reset_valid", instr_valid, 0);
    check("mid_reset_req", rom_req, 0);
    check("mid_reset_addr", rom_addr, 16'h0000);
    cyc(1, 1, 0, 16'h0);
    check("restart_addr", rom_addr, 16'h0000);

    lat_cfg = 3;
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, 16'h0);

    rnd_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 39) == 0), 16'($urandom));
    end

    acks_on = 1'b0;
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 16'h0);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
